// File: rtl/lbp_pkg.sv
// Shared constants for the LBP engine: FSM encodings, default geometry,
// fetch counts and the neighbour-to-window mapping.
package lbp_pkg;

    localparam int DEF_IMG_W = 128;
    localparam int DEF_IMG_H = 128;
    localparam int DEF_AW    = 14;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int FETCH_ROW   = 9;
    localparam int FETCH_SLIDE = 3;

    // Window is stored row-major: index = row*3 + col, center at 4.
    localparam int CENTER_IDX = 4;

    function automatic int nb_drow(input int p);
        case (p)
            0, 1, 2: return -1;
            3, 4:    return 0;
            default: return 1;
        endcase
    endfunction

    function automatic int nb_dcol(input int p);
        case (p)
            0, 3, 5: return -1;
            1, 6:    return 0;
            default: return 1;
        endcase
    endfunction

    function automatic int nb_win_idx(input int p);
        return (nb_drow(p) + 1) * 3 + (nb_dcol(p) + 1);
    endfunction

endpackage

// File: rtl/lbp_code8.sv
// Combinational 8-neighbour LBP code from a packed 3x3 window.
module lbp_code8
    import lbp_pkg::*;
(
    input  logic [71:0] pix,
    output logic [7:0]  code
);

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_bit
            assign code[gi] = (pix[nb_win_idx(gi)*8 +: 8] >= pix[CENTER_IDX*8 +: 8]);
        end
    endgenerate

endmodule

// File: rtl/lbp_core.sv
// LBP engine: streams a grayscale image through a 3x3 sliding window and
// writes one code per interior pixel in raster order.
module lbp_core
    import lbp_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H,
    parameter int AW    = DEF_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          gray_ready,
    output logic          gray_req,
    output logic [AW-1:0] gray_addr,
    input  logic [7:0]    gray_data,
    output logic          lbp_valid,
    output logic [AW-1:0] lbp_addr,
    output logic [7:0]    lbp_data,
    output logic          finish
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = AW - CW;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 2);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 2);

    logic [1:0]    state_reg;
    logic [RW-1:0] row_reg;
    logic [CW-1:0] col_reg;
    logic [3:0]    fidx_reg;
    logic          row_start_reg;
    logic [71:0]   win_reg, win_next;
    logic          gray_req_reg, lbp_valid_reg, finish_reg;
    logic [AW-1:0] gray_addr_reg, lbp_addr_reg;
    logic [7:0]    lbp_data_reg;
    logic [7:0]    code;
    logic [3:0]    cap_slot;
    logic          fetch_last;

    // Row start walks the 3x3 block column-major; a slide fetches the new right column.
    function automatic logic [AW-1:0] fetch_addr(input logic [RW-1:0] r, input logic [CW-1:0] c,
                                                 input logic rs, input logic [3:0] i);
        logic [RW-1:0] ar;
        logic [CW-1:0] ac;
        if (rs) begin
            ar = r - RW'(1) + RW'(i % 4'd3);
            ac = c - CW'(1) + CW'(i / 4'd3);
        end else begin
            ar = r - RW'(1) + RW'(i);
            ac = c + CW'(1);
        end
        return {ar, ac};
    endfunction

    always_comb begin
        win_next   = win_reg;
        fetch_last = (fidx_reg == (row_start_reg ? 4'(FETCH_ROW - 1) : 4'(FETCH_SLIDE - 1)));
        cap_slot   = row_start_reg ? 4'((fidx_reg % 4'd3) * 4'd3 + fidx_reg / 4'd3)
                                   : 4'(fidx_reg * 4'd3 + 4'd2);
        if (state_reg == ST_FETCH && gray_ready) begin
            win_next[cap_slot*8 +: 8] = gray_data;
        end else if (state_reg == ST_WRITE && col_reg < COL_LAST) begin
            for (int r = 0; r < 3; r++) begin
                win_next[(r*3)*8 +: 8]   = win_reg[(r*3+1)*8 +: 8];
                win_next[(r*3+1)*8 +: 8] = win_reg[(r*3+2)*8 +: 8];
            end
        end
    end

    // Code is taken from the window including the pixel captured this edge.
    lbp_code8 u_code (
        .pix  (win_next),
        .code (code)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            row_reg       <= '0;
            col_reg       <= '0;
            fidx_reg      <= '0;
            row_start_reg <= 1'b0;
            win_reg       <= '0;
            gray_req_reg  <= 1'b0;
            gray_addr_reg <= '0;
            lbp_valid_reg <= 1'b0;
            lbp_addr_reg  <= '0;
            lbp_data_reg  <= '0;
            finish_reg    <= 1'b0;
        end else begin
            win_reg <= win_next;
            case (state_reg)
                ST_IDLE: begin
                    if (gray_ready) begin
                        state_reg     <= ST_FETCH;
                        row_reg       <= RW'(1);
                        col_reg       <= CW'(1);
                        row_start_reg <= 1'b1;
                        fidx_reg      <= '0;
                        gray_req_reg  <= 1'b1;
                        gray_addr_reg <= fetch_addr(RW'(1), CW'(1), 1'b1, 4'd0);
                    end
                end
                ST_FETCH: begin
                    if (gray_ready) begin
                        if (fetch_last) begin
                            state_reg     <= ST_WRITE;
                            gray_req_reg  <= 1'b0;
                            lbp_valid_reg <= 1'b1;
                            lbp_addr_reg  <= {row_reg, col_reg};
                            lbp_data_reg  <= code;
                        end else begin
                            fidx_reg      <= fidx_reg + 4'd1;
                            gray_addr_reg <= fetch_addr(row_reg, col_reg, row_start_reg,
                                                        fidx_reg + 4'd1);
                        end
                    end
                end
                ST_WRITE: begin
                    lbp_valid_reg <= 1'b0;
                    fidx_reg      <= '0;
                    if (col_reg < COL_LAST) begin
                        state_reg     <= ST_FETCH;
                        col_reg       <= col_reg + CW'(1);
                        row_start_reg <= 1'b0;
                        gray_req_reg  <= 1'b1;
                        gray_addr_reg <= fetch_addr(row_reg, col_reg + CW'(1), 1'b0, 4'd0);
                    end else if (row_reg < ROW_LAST) begin
                        state_reg     <= ST_FETCH;
                        row_reg       <= row_reg + RW'(1);
                        col_reg       <= CW'(1);
                        row_start_reg <= 1'b1;
                        gray_req_reg  <= 1'b1;
                        gray_addr_reg <= fetch_addr(row_reg + RW'(1), CW'(1), 1'b1, 4'd0);
                    end else begin
                        state_reg  <= ST_DONE;
                        finish_reg <= 1'b1;
                    end
                end
                default: begin
                    gray_req_reg  <= 1'b0;
                    lbp_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign gray_req  = gray_req_reg;
    assign gray_addr = gray_addr_reg;
    assign lbp_valid = lbp_valid_reg;
    assign lbp_addr  = lbp_addr_reg;
    assign lbp_data  = lbp_data_reg;
    assign finish    = finish_reg;

endmodule

// File: tb/tb_lbp_core.sv
// Bench for lbp_core on a reduced 16x16 image with an image-memory model
// and a scoreboard of expected (address, code) writes.
module tb_lbp_core;

    localparam int W      = 16;
    localparam int H      = 16;
    localparam int AWB    = 8;
    localparam int NWR    = (W - 2) * (H - 2);
    localparam int BUDGET = (H - 2) * (10 + (W - 3) * 4) + 40;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           gray_ready = 1'b0;
    logic           gray_req;
    logic [AWB-1:0] gray_addr;
    logic [7:0]     gray_data;
    logic           lbp_valid;
    logic [AWB-1:0] lbp_addr;
    logic [7:0]     lbp_data;
    logic           finish;

    logic [7:0]     img [W*H];
    logic [7:0]     res [W*H];
    logic [AWB+7:0] exp_q [$];
    logic [AWB+7:0] obs_q [$];
    int n_cmp = 0;
    int n_bad = 0;
    int pulses = 0;
    int border_hits = 0;
    int finish_rises = 0;
    logic finish_d = 1'b0;
    int dr [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
    int dc [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};

    always #5 clk = ~clk;

    // Garbage while not ready, so a capture during a stall would corrupt results.
    assign gray_data = gray_ready ? img[gray_addr] : 8'h5A;

    lbp_core #(.IMG_W(W), .IMG_H(H), .AW(AWB)) dut (
        .clk        (clk),
        .reset      (reset),
        .gray_ready (gray_ready),
        .gray_req   (gray_req),
        .gray_addr  (gray_addr),
        .gray_data  (gray_data),
        .lbp_valid  (lbp_valid),
        .lbp_addr   (lbp_addr),
        .lbp_data   (lbp_data),
        .finish     (finish)
    );

    // Result memory model plus write monitor; the memory is wiped while reset is high.
    always @(negedge clk) begin
        int a;
        if (reset) begin
            foreach (res[i]) res[i] = 8'h00;
            obs_q.delete();
        end else if (lbp_valid) begin
            a = int'(lbp_addr);
            obs_q.push_back({lbp_addr, lbp_data});
            res[a] = lbp_data;
            pulses++;
            if (a / W == 0 || a / W == H - 1 || a % W == 0 || a % W == W - 1) border_hits++;
        end
        if (finish && !finish_d) finish_rises++;
        finish_d = finish;
    end

    function automatic logic [7:0] model_code(int r, int c);
        logic [7:0] code;
        code = 8'h00;
        for (int p = 0; p < 8; p++)
            if (img[(r + dr[p]) * W + c + dc[p]] >= img[r * W + c]) code[p] = 1'b1;
        return code;
    endfunction

    task automatic push_expected();
        exp_q.delete();
        for (int r = 1; r < H - 1; r++)
            for (int c = 1; c < W - 1; c++)
                exp_q.push_back({AWB'(r * W + c), model_code(r, c)});
    endtask

    task automatic do_reset();
        gray_ready = 1'b0;
        @(negedge clk) reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_finish(output int cyc);
        cyc = 0;
        while (finish !== 1'b1 && cyc < BUDGET + 20) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got req=%b gaddr=%0d valid=%b laddr=%0d data=%02h fin=%b, want all 0",
                     gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish);
        end
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_cmp++;
            if (gray_req !== 1'b0) begin
                n_bad++;
                $display("FAIL idle_no_req: cycle %0d got gray_req=%b, want 0", k, gray_req);
            end
        end
    endtask

    task automatic test_uniform();
        int cyc, p0, b0, f0, nz;
        logic [AWB+7:0] o, e;
        foreach (img[i]) img[i] = 8'h64;
        do_reset();
        push_expected();
        p0 = pulses; b0 = border_hits; f0 = finish_rises;
        gray_ready = 1'b1;
        wait_finish(cyc);
        n_cmp++;
        if (cyc > BUDGET) begin
            n_bad++;
            $display("FAIL uniform_latency: got %0d cycles, want <= %0d", cyc, BUDGET);
        end
        repeat (3) @(negedge clk);
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL uniform_write: got addr %0d code %02h, want addr %0d code %02h",
                         o[AWB+7:8], o[7:0], e[AWB+7:8], e[7:0]);
            end
        end
        n_cmp++;
        if (pulses - p0 !== NWR || obs_q.size() != 0 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL uniform_count: got %0d pulses (%0d extra, %0d missing), want %0d",
                     pulses - p0, obs_q.size(), exp_q.size(), NWR);
        end
        nz = 0;
        for (int a = 0; a < W * H; a++)
            if ((a / W == 0 || a / W == H - 1 || a % W == 0 || a % W == W - 1) && res[a] !== 8'h00) nz++;
        n_cmp++;
        if (nz !== 0 || border_hits - b0 !== 0) begin
            n_bad++;
            $display("FAIL uniform_border: got %0d nonzero border cells, %0d border writes, want 0 and 0",
                     nz, border_hits - b0);
        end
        n_cmp++;
        if (finish !== 1'b1 || finish_rises - f0 !== 1) begin
            n_bad++;
            $display("FAIL uniform_finish: got finish=%b rises=%0d, want 1 and 1", finish, finish_rises - f0);
        end
    endtask

    task automatic test_column();
        int cyc, b0;
        logic [AWB+7:0] o, e;
        for (int a = 0; a < W * H; a++) img[a] = 8'(a % W);
        do_reset();
        push_expected();
        b0 = border_hits;
        gray_ready = 1'b1;
        wait_finish(cyc);
        repeat (2) @(negedge clk);
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL column_write: got addr %0d code %02h, want addr %0d code %02h",
                         o[AWB+7:8], o[7:0], e[AWB+7:8], e[7:0]);
            end
        end
        n_cmp++;
        if (obs_q.size() != 0 || exp_q.size() != 0 || border_hits - b0 !== 0) begin
            n_bad++;
            $display("FAIL column_count: got %0d extra, %0d missing, %0d border writes, want 0/0/0",
                     obs_q.size(), exp_q.size(), border_hits - b0);
        end
        n_cmp++;
        if (res[5 * W + 5] !== 8'hD6 || res[1 * W + (W - 2)] !== 8'hD6) begin
            n_bad++;
            $display("FAIL column_code: got %02h and %02h, want d6 and d6", res[5 * W + 5], res[W + W - 2]);
        end
    endtask

    task automatic test_dip();
        int cyc;
        int pos [5] = '{8 * W + 8, 7 * W + 7, 7 * W + 8, 9 * W + 9, 8 * W + 9};
        logic [7:0] want [5] = '{8'hFF, 8'h7F, 8'hBF, 8'hFE, 8'hF7};
        logic [AWB+7:0] o, e;
        foreach (img[i]) img[i] = 8'd100;
        img[8 * W + 8] = 8'd0;
        do_reset();
        push_expected();
        gray_ready = 1'b1;
        wait_finish(cyc);
        repeat (2) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (res[pos[k]] !== want[k]) begin
                n_bad++;
                $display("FAIL dip_code: addr %0d got %02h, want %02h", pos[k], res[pos[k]], want[k]);
            end
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL dip_write: got addr %0d code %02h, want addr %0d code %02h",
                         o[AWB+7:8], o[7:0], e[AWB+7:8], e[7:0]);
            end
        end
        n_cmp++;
        if (obs_q.size() != 0 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL dip_count: got %0d extra, %0d missing writes, want 0 and 0", obs_q.size(), exp_q.size());
        end
    endtask

    task automatic test_stall();
        int cyc, cyc2;
        logic [AWB-1:0] held;
        logic [AWB+7:0] o, e;
        foreach (img[i]) img[i] = 8'($urandom_range(0, 4) * 60);
        do_reset();
        push_expected();
        gray_ready = 1'b1;
        cyc = 0;
        while (!(cyc >= 30 && gray_req === 1'b1) && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
        end
        held = gray_addr;
        gray_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_cmp++;
            if (gray_req !== 1'b1 || gray_addr !== held) begin
                n_bad++;
                $display("FAIL stall_hold: cycle %0d got req=%b addr=%0d, want req=1 addr=%0d",
                         k, gray_req, gray_addr, held);
            end
        end
        gray_ready = 1'b1;
        wait_finish(cyc2);
        n_cmp++;
        if (cyc + cyc2 > BUDGET) begin
            n_bad++;
            $display("FAIL stall_latency: got %0d cycles, want <= %0d", cyc + cyc2, BUDGET);
        end
        repeat (2) @(negedge clk);
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL stall_write: got addr %0d code %02h, want addr %0d code %02h",
                         o[AWB+7:8], o[7:0], e[AWB+7:8], e[7:0]);
            end
        end
        n_cmp++;
        if (obs_q.size() != 0 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL stall_count: got %0d extra, %0d missing writes, want 0 and 0", obs_q.size(), exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int cyc, p0, f0;
        logic [AWB+7:0] o, e;
        foreach (img[i]) img[i] = 8'($urandom_range(0, 255));
        do_reset();
        gray_ready = 1'b1;
        repeat (400) @(negedge clk);
        reset = 1'b1;
        gray_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish} !== '0) begin
            n_bad++;
            $display("FAIL midreset_outputs: got req=%b gaddr=%0d valid=%b laddr=%0d data=%02h fin=%b, want all 0",
                     gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish);
        end
        @(negedge clk) reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (gray_req !== 1'b0 || lbp_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL midreset_idle: cycle %0d got req=%b valid=%b, want 0 and 0", k, gray_req, lbp_valid);
            end
        end
        push_expected();
        p0 = pulses; f0 = finish_rises;
        gray_ready = 1'b1;
        wait_finish(cyc);
        repeat (3) @(negedge clk);
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL midreset_write: got addr %0d code %02h, want addr %0d code %02h",
                         o[AWB+7:8], o[7:0], e[AWB+7:8], e[7:0]);
            end
        end
        n_cmp++;
        if (pulses - p0 !== NWR || finish_rises - f0 !== 1 || cyc > BUDGET) begin
            n_bad++;
            $display("FAIL midreset_run: got %0d pulses, %0d finish rises, %0d cycles, want %0d, 1, <= %0d",
                     pulses - p0, finish_rises - f0, cyc, NWR, BUDGET);
        end
    endtask

    initial begin
        test_reset();
        test_uniform();
        test_column();
        test_dip();
        test_stall();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
